i2s_tx_framer: RTL and testbench

I2S_TX_FRAMER -- requirements
Module: i2s_tx_framer

---
 rtl/i2s_tx_framer.sv | 155 +++++++++++++++
 tb/tb_i2s_tx_framer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_framer.sv
// i2s_tx_framer: serialises stereo sample pairs into a Philips I2S stream.
//
// One pending-pair register decouples the input handshake from frame timing.
// At each frame boundary (load tick) the pending pair moves into the frame
// shift register. If nothing is pending, the frame underruns and a fill pair
// is transmitted instead.
//
// Build option:
//   I2S_TX_UNDERRUN_HOLD_EN - when defined, an underrun frame repeats the last
//                             loaded pair (zero after reset); otherwise an
//                             underrun frame carries an all-zero pair.
//
// Parameters:
//   WORD_SIZE   - bit slots per channel
//   SAMPLE_SIZE - MSB-aligned sample width, at most WORD_SIZE-1
//
// Ports:
//   clk         - system clock, twice the BCK rate
//   rst         - synchronous, active-high reset
//   s_valid     - stereo pair offered
//   s_ready     - pair accepted when s_valid & s_ready at a rising clk edge
//   s_left      - signed left sample
//   s_right     - signed right sample
//   bck         - I2S bit clock, clk/2
//   lrck        - word select, 0 = left, 1 = right
//   sdata       - serial data, MSB first, one slot after each lrck edge
//   frame_start - one-clk pulse when a frame loads
//   underrun    - one-clk pulse when a frame loads with no pending pair
module i2s_tx_framer #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned SAMPLE_SIZE = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [SAMPLE_SIZE-1:0] s_left,
  input  logic [SAMPLE_SIZE-1:0] s_right,
  output logic                   bck,
  output logic                   lrck,
  output logic                   sdata,
  output logic                   frame_start,
  output logic                   underrun
);

  localparam int unsigned Slots = 2 * WORD_SIZE;
  localparam int unsigned CntW  = $clog2(Slots);
  // The shift register covers slots 1..Slots-1; slot 0 is always a zero.
  localparam int unsigned SrW   = Slots - 1;

  localparam logic [CntW-1:0] LastSlot = CntW'(Slots - 1);
  localparam logic [CntW-1:0] WordSlot = CntW'(WORD_SIZE);

  logic                   phase_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic                   lrck_q;
  logic                   sdata_q;
  logic                   frame_start_q;
  logic                   underrun_q;
  logic                   pend_full_q;
  logic [SAMPLE_SIZE-1:0] pend_l_q;
  logic [SAMPLE_SIZE-1:0] pend_r_q;
  logic [SrW-1:0]         shift_q;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  logic [SAMPLE_SIZE-1:0] last_l_q;
  logic [SAMPLE_SIZE-1:0] last_r_q;
`endif

  logic                   fall_tick;
  logic                   load_tick;
  logic                   accept;
  logic [CntW-1:0]        cnt_next;
  logic [SAMPLE_SIZE-1:0] fill_l;
  logic [SAMPLE_SIZE-1:0] fill_r;
  logic [SAMPLE_SIZE-1:0] load_l;
  logic [SAMPLE_SIZE-1:0] load_r;
  logic [SrW-1:0]         frame_bits;

  always_comb begin
    // phase_q high means this edge takes bck from 1 to 0.
    fall_tick = phase_q;
    cnt_next  = (bit_cnt_q == LastSlot) ? '0 : bit_cnt_q + 1'b1;
    load_tick = fall_tick & (bit_cnt_q == LastSlot);
    accept    = s_valid & ~pend_full_q;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    fill_l = last_l_q;
    fill_r = last_r_q;
`else
    fill_l = '0;
    fill_r = '0;
`endif
    load_l = pend_full_q ? pend_l_q : fill_l;
    load_r = pend_full_q ? pend_r_q : fill_r;
    // Left lands in slots 1..SAMPLE_SIZE, right in WORD_SIZE+1..WORD_SIZE+SAMPLE_SIZE;
    // bit SrW-1 is transmitted in slot 1.
    frame_bits = (SrW'(load_l) << (SrW - SAMPLE_SIZE))
               | (SrW'(load_r) << (WORD_SIZE - 1 - SAMPLE_SIZE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= 1'b0;
      bit_cnt_q     <= LastSlot;
      lrck_q        <= 1'b1;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      pend_full_q   <= 1'b0;
      pend_l_q      <= '0;
      pend_r_q      <= '0;
      shift_q       <= '0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      last_l_q      <= '0;
      last_r_q      <= '0;
`endif
    end else begin
      phase_q       <= ~phase_q;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      if (fall_tick) begin
        bit_cnt_q <= cnt_next;
        lrck_q    <= (cnt_next >= WordSlot);
        if (load_tick) begin
          sdata_q       <= 1'b0;
          shift_q       <= frame_bits;
          frame_start_q <= 1'b1;
          underrun_q    <= ~pend_full_q;
          pend_full_q   <= 1'b0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
          last_l_q      <= load_l;
          last_r_q      <= load_r;
`endif
        end else begin
          sdata_q <= shift_q[SrW-1];
          shift_q <= {shift_q[SrW-2:0], 1'b0};
        end
      end
      // A handshake on an underrun load tick becomes pending for the next frame;
      // this later assignment overrides the clear above.
      if (accept) begin
        pend_l_q    <= s_left;
        pend_r_q    <= s_right;
        pend_full_q <= 1'b1;
      end
    end
  end

  assign s_ready     = ~pend_full_q;
  assign bck         = phase_q;
  assign lrck        = lrck_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_framer.sv
module tb_i2s_tx_framer;

  localparam int W = 32;
  localparam int S = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic [S-1:0] s_left = '0;
  logic [S-1:0] s_right = '0;
  logic         s_ready;
  logic         bck;
  logic         lrck;
  logic         sdata;
  logic         frame_start;
  logic         underrun;

  i2s_tx_framer #(
    .WORD_SIZE  (W),
    .SAMPLE_SIZE(S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .bck        (bck),
    .lrck       (lrck),
    .sdata      (sdata),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state, advanced at each rising edge.
  logic [2*S-1:0] q[$];
  logic [2*S-1:0] act;
  logic [2*S-1:0] last;
  bit             m_phase;
  int             m_slot;
  logic           e_fs, e_ur, e_lrck, e_sd;
  int             fs_cnt  = 0;
  int             ur_cnt  = 0;
  int             acc_cnt = 0;

  function automatic logic slot_bit(int slot, logic [S-1:0] l, logic [S-1:0] r);
    logic [S-1:0] t;
    if (slot >= 1 && slot <= S) begin
      t = l >> (S - slot);
      return t[0];
    end
    if (slot >= W + 1 && slot <= W + S) begin
      t = r >> (W + S - slot);
      return t[0];
    end
    return 1'b0;
  endfunction

  task automatic scoreboard();
    bit hs;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 1'b0;
        m_slot  = 2 * W - 1;
        q.delete();
        act    = '0;
        last   = '0;
        e_fs   = 1'b0;
        e_ur   = 1'b0;
        e_lrck = 1'b1;
        e_sd   = 1'b0;
      end else begin
        hs   = s_valid && (q.size() == 0);
        e_fs = 1'b0;
        e_ur = 1'b0;
        if (m_phase) begin
          m_slot = (m_slot == 2 * W - 1) ? 0 : m_slot + 1;
          if (m_slot == 0) begin
            e_fs = 1'b1;
            fs_cnt++;
            if (q.size() > 0) begin
              act = q.pop_front();
            end else begin
              e_ur = 1'b1;
              ur_cnt++;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
              act = last;
`else
              act = '0;
`endif
            end
            last = act;
          end
          e_lrck = (m_slot >= W);
          e_sd   = slot_bit(m_slot, act[2*S-1:S], act[S-1:0]);
        end
        if (hs) begin
          q.push_back({s_left, s_right});
          acc_cnt++;
        end
        m_phase = ~m_phase;
      end
      #1;
      total++;
      if (bck !== m_phase) begin
        bad++;
        $display("FAIL bck t=%0t got=%b want=%b", $time, bck, m_phase);
      end
      total++;
      if (lrck !== e_lrck) begin
        bad++;
        $display("FAIL lrck t=%0t slot=%0d got=%b want=%b", $time, m_slot, lrck, e_lrck);
      end
      total++;
      if (sdata !== e_sd) begin
        bad++;
        $display("FAIL sdata t=%0t slot=%0d got=%b want=%b", $time, m_slot, sdata, e_sd);
      end
      total++;
      if (frame_start !== e_fs) begin
        bad++;
        $display("FAIL frame_start t=%0t got=%b want=%b", $time, frame_start, e_fs);
      end
      total++;
      if (underrun !== e_ur) begin
        bad++;
        $display("FAIL underrun t=%0t got=%b want=%b", $time, underrun, e_ur);
      end
      total++;
      if (s_ready !== (q.size() == 0)) begin
        bad++;
        $display("FAIL s_ready t=%0t got=%b want=%b", $time, s_ready, q.size() == 0);
      end
    end
  endtask

  // Wait for n more frame loads, seen at falling edges; bounded.
  task automatic wait_frames(int n);
    int target;
    target = fs_cnt + n;
    for (int i = 0; i < (n + 1) * 2 * 2 * W; i++) begin
      @(negedge clk);
      if (fs_cnt >= target) return;
    end
    total++;
    bad++;
    $display("FAIL wait_frames timeout got=%0d want=%0d", fs_cnt, target);
  endtask

  task automatic test_reset();
    logic [5:0] vec;
    int found, lr0, lr1, bk0, bk1, ones;
    logic plr, pbk;
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    vec = {bck, lrck, sdata, frame_start, underrun, s_ready};
    total++;
    if (vec !== 6'b010001) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", vec, 6'b010001);
    end
    rst = 1'b0;
    found = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1) begin
        found = i;
        break;
      end
    end
    total++;
    if (found != 2) begin
      bad++;
      $display("FAIL first_load_latency got=%0d want=2", found);
    end
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL first_load_underrun got=%b want=1", underrun);
    end
    lr0 = -1; lr1 = -1; bk0 = -1; bk1 = -1; ones = 0;
    plr = lrck;
    pbk = bck;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (sdata === 1'b1) ones++;
      if (lrck && !plr) begin
        if (lr0 < 0) lr0 = k;
        else if (lr1 < 0) lr1 = k;
      end
      if (bck && !pbk) begin
        if (bk0 < 0) bk0 = k;
        else if (bk1 < 0) bk1 = k;
      end
      plr = lrck;
      pbk = bck;
    end
    total++;
    if (lr1 - lr0 != 4 * W || lr0 < 0) begin
      bad++;
      $display("FAIL lrck_period got=%0d want=%0d", lr1 - lr0, 4 * W);
    end
    total++;
    if (bk1 - bk0 != 2 || bk0 < 0) begin
      bad++;
      $display("FAIL bck_period got=%0d want=2", bk1 - bk0);
    end
    total++;
    if (ones != 0) begin
      bad++;
      $display("FAIL idle_sdata ones got=%0d want=0", ones);
    end
  endtask

  // Pair offered on the first load tick: that frame underruns, the next carries it.
  task automatic test_first_pair();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_left  = 24'h800001;
    s_right = 24'h7FFFFE;
    @(posedge clk);
    #1;
    total++;
    if ({frame_start, underrun} !== 2'b11) begin
      bad++;
      $display("FAIL first_pair_underrun got=%b want=11", {frame_start, underrun});
    end
    @(negedge clk);
    s_valid = 1'b0;
    total++;
    if (s_ready !== 1'b0) begin
      bad++;
      $display("FAIL first_pair_pending got=%b want=0", s_ready);
    end
    wait_frames(2);
  endtask

  task automatic test_stream();
    int idx, start, acc0, ur0;
    bit will, snap;
    idx = 0;
    snap = 1'b0;
    acc0 = 0;
    ur0 = 0;
    start = fs_cnt;
    @(negedge clk);
    s_valid = 1'b1;
    s_left  = 24'h100000;
    s_right = 24'hE00000;
    will = s_ready;
    for (int c = 0; c < 7 * 4 * W; c++) begin
      @(negedge clk);
      if (will) begin
        idx++;
        s_left  = 24'h100000 + S'(idx);
        s_right = 24'hE00000 - S'(idx);
      end
      will = s_ready;
      if (!snap && fs_cnt == start + 1) begin
        snap = 1'b1;
        acc0 = acc_cnt;
        ur0  = ur_cnt;
      end
      if (fs_cnt == start + 5) break;
    end
    s_valid = 1'b0;
    total++;
    if (acc_cnt - acc0 != 4 || !snap) begin
      bad++;
      $display("FAIL stream_accepts got=%0d want=4", acc_cnt - acc0);
    end
    total++;
    if (ur_cnt - ur0 != 0) begin
      bad++;
      $display("FAIL stream_underruns got=%0d want=0", ur_cnt - ur0);
    end
    wait_frames(2);
  endtask

  task automatic test_coincide();
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 12 * W; c++) begin
      @(negedge clk);
      if (m_phase && m_slot == 2 * W - 1 && q.size() == 0) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL coincide_timeout got=0 want=1");
      return;
    end
    s_valid = 1'b1;
    s_left  = 24'h123456;
    s_right = 24'h654321;
    @(posedge clk);
    #1;
    total++;
    if ({frame_start, underrun} !== 2'b11) begin
      bad++;
      $display("FAIL coincide_underrun got=%b want=11", {frame_start, underrun});
    end
    @(negedge clk);
    s_valid = 1'b0;
    total++;
    if (s_ready !== 1'b0) begin
      bad++;
      $display("FAIL coincide_pending got=%b want=0", s_ready);
    end
    wait_frames(2);
  endtask

  task automatic test_hold();
    int acc0, ur0;
    wait_frames(1);
    acc0 = acc_cnt;
    s_valid = 1'b1;
    s_left  = 24'h0F0F0F;
    s_right = 24'hF0F0F0;
    @(negedge clk);
    s_valid = 1'b0;
    total++;
    if (acc_cnt - acc0 != 1) begin
      bad++;
      $display("FAIL hold_accept got=%0d want=1", acc_cnt - acc0);
    end
    ur0 = ur_cnt;
    wait_frames(4);
    total++;
    if (ur_cnt - ur0 != 3) begin
      bad++;
      $display("FAIL hold_underruns got=%0d want=3", ur_cnt - ur0);
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] vec;
    int found;
    bit hit;
    wait_frames(1);
    s_valid = 1'b1;
    s_left  = 24'hABCDEF;
    s_right = 24'h135790;
    @(negedge clk);
    s_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 8 * W; c++) begin
      @(negedge clk);
      if (m_slot == 40) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!hit || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_setup got=%b want=0", s_ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    vec = {bck, lrck, sdata, frame_start, underrun, s_ready};
    total++;
    if (vec !== 6'b010001) begin
      bad++;
      $display("FAIL mid_reset_state got=%b want=%b", vec, 6'b010001);
    end
    @(negedge clk);
    rst = 1'b0;
    found = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1) begin
        found = i;
        break;
      end
    end
    total++;
    if (found != 2) begin
      bad++;
      $display("FAIL mid_reset_restart got=%0d want=2", found);
    end
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_discard got=%b want=1", underrun);
    end
    wait_frames(1);
  endtask

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_first_pair();
    test_stream();
    test_coincide();
    test_hold();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
